// File: rtl/emg_multichan_pipe_out_if.sv
// ---------------------------------------------------------------------------
// emg_multichan_pipe_out_if
// Pipe-out read handshake between the EMG frame buffer and the host pipe
// endpoint (okBTPipeOut style).
//   ep_read   : pop strobe, one word per asserted ti_clk cycle
//   ep_datain : FIFO head word (FWFT), 16'h0000 when empty
//   ep_ready  : a full block of words is available
// Modports: slave = buffer side, master = host/endpoint side.
// ---------------------------------------------------------------------------
interface emg_multichan_pipe_out_if;
    logic        ep_read;
    logic [15:0] ep_datain;
    logic        ep_ready;

    modport master (output ep_read, input ep_datain, input ep_ready);
    modport slave  (input ep_read, output ep_datain, output ep_ready);
endinterface

// File: rtl/emg_multichan_pipe_out.sv
// ---------------------------------------------------------------------------
// emg_multichan_pipe_out
// Snapshots NCH signed EMG samples on each (synchronised) sample tick and
// serialises them as a tagged frame of 16-bit words into an FWFT FIFO that
// drains through a pipe-out read interface.
//   Frame: header (frame number), then per channel low word, high word
//   (high word sign-extended). Optional checksum word: define
//   EMG_FRAME_CHECKSUM_EN to append the XOR of all preceding frame words.
// Ports:
//   ti_clk, reset_global (async, active-high)
//   sample_tick : sim_clk-domain strobe, synchronised here
//   emg_in      : NCH packed samples, ch k at [k*SAMPLE_W +: SAMPLE_W]
//   enable      : capture enable
//   pipe        : read handshake (ep_read / ep_datain / ep_ready)
//   fill_level  : words stored
//   frame_cnt   : frames attempted, drop_cnt : frames dropped (saturating)
//   underflow   : sticky, read attempted while empty
// ---------------------------------------------------------------------------

// Per-channel word split: sign-extend to 32 bits, then cut into two halves.
module emg_chan_words #(
    parameter int SAMPLE_W = 18
) (
    input  logic [SAMPLE_W-1:0] sample,
    output logic [15:0]         lo,
    output logic [15:0]         hi
);
    logic [31:0] ext;
    assign ext = 32'($signed(sample));
    assign lo  = ext[15:0];
    assign hi  = ext[31:16];
endmodule

module emg_multichan_pipe_out #(
    parameter int NCH         = 4,
    parameter int SAMPLE_W    = 18,
    parameter int DEPTH       = 512,
    parameter int BLOCK_WORDS = 32
) (
    input  logic                      ti_clk,
    input  logic                      reset_global,
    input  logic                      sample_tick,
    input  logic [NCH*SAMPLE_W-1:0]   emg_in,
    input  logic                      enable,
    emg_multichan_pipe_out_if.slave   pipe,
    output logic [$clog2(DEPTH):0]    fill_level,
    output logic [15:0]               frame_cnt,
    output logic [15:0]               drop_cnt,
    output logic                      underflow
);
    localparam int AW  = $clog2(DEPTH);
    localparam int FW  = AW + 1;
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
`ifdef EMG_FRAME_CHECKSUM_EN
    localparam int FRAME_WORDS = 2 + 2*NCH;
`else
    localparam int FRAME_WORDS = 1 + 2*NCH;
`endif

    typedef enum logic [2:0] {IDLE, HDR, CH_LO, CH_HI, CSUM} state_t;

    // ---------------- tick synchroniser + rising edge ----------------
    // [0],[1] are the 2-FF synchroniser, [2] holds the previous synced level.
    logic [2:0] tick_sync;
    logic       tick_p;

    always_ff @(posedge ti_clk or posedge reset_global) begin
        if (reset_global) begin
            tick_sync <= '0;
            tick_p    <= 1'b0;
        end else begin
            tick_sync <= {tick_sync[1:0], sample_tick};
            tick_p    <= tick_sync[1] & ~tick_sync[2];
        end
    end

    // ---------------- snapshot and per-channel words ----------------
    logic [NCH-1:0][SAMPLE_W-1:0] snap;
    logic [NCH-1:0][15:0]         lo_w, hi_w;

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        emg_chan_words #(.SAMPLE_W(SAMPLE_W)) u_chan (
            .sample (snap[k]),
            .lo     (lo_w[k]),
            .hi     (hi_w[k])
        );
    end

    // ---------------- frame FSM ----------------
    state_t         state_q, state_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic [15:0]    hdr_q;
    logic           wr_en;
    logic [15:0]    wr_data;
    logic           accept, drop, space_ok;
`ifdef EMG_FRAME_CHECKSUM_EN
    logic [15:0]    csum_q;
`endif

    // Space is reserved for the whole frame up front; reads during the frame
    // only free more space, so the frame can never hit a full FIFO.
    assign space_ok = (FW'(DEPTH) - fill_level) >= FW'(FRAME_WORDS);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        wr_en   = 1'b0;
        wr_data = 16'h0000;
        accept  = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick_p && enable) begin
                    if (space_ok) begin
                        accept  = 1'b1;
                        state_d = HDR;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            HDR: begin
                wr_en   = 1'b1;
                wr_data = hdr_q;
                ch_d    = '0;
                state_d = CH_LO;
            end
            CH_LO: begin
                wr_en   = 1'b1;
                wr_data = lo_w[ch_q];
                state_d = CH_HI;
            end
            CH_HI: begin
                wr_en   = 1'b1;
                wr_data = hi_w[ch_q];
                if (ch_q == CHW'(NCH-1)) begin
`ifdef EMG_FRAME_CHECKSUM_EN
                    state_d = CSUM;
`else
                    state_d = IDLE;
`endif
                end else begin
                    ch_d    = ch_q + CHW'(1);
                    state_d = CH_LO;
                end
            end
`ifdef EMG_FRAME_CHECKSUM_EN
            CSUM: begin
                wr_en   = 1'b1;
                wr_data = csum_q;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
        // A tick landing mid-frame is counted as an attempted, dropped frame.
        if (tick_p && state_q != IDLE) drop = 1'b1;
    end

    always_ff @(posedge ti_clk or posedge reset_global) begin
        if (reset_global) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            snap      <= '0;
            hdr_q     <= 16'h0000;
            frame_cnt <= 16'h0000;
            drop_cnt  <= 16'h0000;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            if (accept) begin
                snap  <= emg_in;
                hdr_q <= frame_cnt;
            end
            if (accept || drop) frame_cnt <= frame_cnt + 16'd1;
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

`ifdef EMG_FRAME_CHECKSUM_EN
    always_ff @(posedge ti_clk or posedge reset_global) begin
        if (reset_global)  csum_q <= 16'h0000;
        else if (accept)   csum_q <= 16'h0000;
        else if (wr_en)    csum_q <= csum_q ^ wr_data;
    end
`endif

    // ---------------- FWFT FIFO ----------------
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          rd_en;

    assign rd_en          = pipe.ep_read && (fill_level != '0);
    assign pipe.ep_datain = (fill_level != '0) ? mem[rd_ptr] : 16'h0000;

    always_ff @(posedge ti_clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge ti_clk or posedge reset_global) begin
        if (reset_global) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fill_level    <= '0;
            underflow     <= 1'b0;
            pipe.ep_ready <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            fill_level <= fill_level + FW'(wr_en) - FW'(rd_en);
            if (pipe.ep_read && fill_level == '0) underflow <= 1'b1;
            // Registered from the current count, so it trails fill by a cycle.
            pipe.ep_ready <= fill_level >= FW'(BLOCK_WORDS);
        end
    end
endmodule
